// File: rtl/joy_serializer.sv
// joy_serializer: parallel-in/serial-out transmitter for the serial joystick link.
// Define JOYSER_TIMEOUT_EN to add the TIMEOUT watchdog and the link_lost output.
module joy_serializer #(
    parameter int unsigned LEAD_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
`ifdef JOYSER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT     = 1 << 20
`endif
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    input  logic [11:0] joystick1,
    input  logic [11:0] joystick2,
    output logic        frame_done,
    output logic [4:0]  bit_index
`ifdef JOYSER_TIMEOUT_EN
    ,
    output logic        link_lost
`endif
);
    localparam int unsigned FLEN     = LEAD_BITS + 24;
    localparam logic [4:0]  LAST_IDX = 5'(FLEN - 1);

    typedef enum logic [1:0] {IDLE, LOADING, SHIFTING, DONE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync_q, load_sync_q;
    logic                   clk_s_d_q;
    logic                   clk_s, load_s, rise;
    logic [23:0]            payload;
    logic [FLEN-1:0]        snapshot, shreg_q, shreg_d;
    logic [4:0]             bit_index_q, bit_index_d;
    logic                   joy_data_q, joy_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   force_idle;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign load_s = load_sync_q[SYNC_STAGES-1];
    assign rise   = clk_s & ~clk_s_d_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_sync_q  <= '1;
            load_sync_q <= '1;
            clk_s_d_q   <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load};
            clk_s_d_q   <= clk_s;
        end
    end

    // Payload bit k sits at payload[k]; the frame shifts out LSB first.
    assign payload = {joystick1[7], joystick1[9], joystick1[11], joystick1[10],
                      joystick2[7], joystick2[9], joystick2[11], joystick2[10],
                      joystick2[0], joystick2[1], joystick2[2], joystick2[3],
                      joystick2[4], joystick2[5], joystick2[6], joystick2[8],
                      joystick1[0], joystick1[1], joystick1[2], joystick1[3],
                      joystick1[4], joystick1[5], joystick1[6], joystick1[8]};

    always_comb begin
        snapshot                      = '1;
        snapshot[FLEN-1:LEAD_BITS]    = payload;
    end

    always_ff @(posedge CLK) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!load_s) begin
            state_d = LOADING;
        end else begin
            case (state_q)
                LOADING:  state_d = SHIFTING;
                SHIFTING: if (rise && bit_index_q == LAST_IDX) state_d = DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shreg_d      = shreg_q;
        bit_index_d  = bit_index_q;
        frame_done_d = 1'b0;
        if (!load_s) begin
            shreg_d     = snapshot;
            bit_index_d = '0;
        end else if (state_q == SHIFTING && rise) begin
            shreg_d      = {1'b1, shreg_q[FLEN-1:1]};
            bit_index_d  = bit_index_q + 5'd1;
            frame_done_d = (bit_index_q == LAST_IDX);
        end
        joy_data_d = force_idle | (state_d == IDLE) | (state_d == DONE) | shreg_d[0];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            shreg_q      <= '1;
            bit_index_q  <= '0;
            joy_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_index_q  <= bit_index_d;
            joy_data_q   <= joy_data_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef JOYSER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          load_s_d_q, load_fall;
    logic          link_lost_q, link_lost_d;

    assign load_fall = ~load_s & load_s_d_q;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (load_fall)                     wd_cnt_d = '0;
        else if (wd_cnt_q != CW'(TIMEOUT)) wd_cnt_d = wd_cnt_q + CW'(1);
        link_lost_d = !load_fall && (wd_cnt_d == CW'(TIMEOUT));
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wd_cnt_q    <= '0;
            load_s_d_q  <= 1'b1;
            link_lost_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            load_s_d_q  <= load_s;
            link_lost_q <= link_lost_d;
        end
    end

    assign force_idle = link_lost_d;
    assign link_lost  = link_lost_q;
`else
    assign force_idle = 1'b0;
`endif

    assign joy_data   = joy_data_q;
    assign frame_done = frame_done_q;
    assign bit_index  = bit_index_q;
endmodule

// File: tb/tb_joy_serializer.sv
// Scoreboard bench for joy_serializer: expected frame bits are queued at load
// release and popped as the deserializer side samples before each joy_clk rise.
module tb_joy_serializer;
    localparam int unsigned LEAD = 1;
    localparam int unsigned SYNC = 2;
    localparam int unsigned FLEN = LEAD + 24;
    localparam int unsigned HALF = 16;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic [11:0] joystick1 = '1;
    logic [11:0] joystick2 = '1;
    logic        joy_data;
    logic        frame_done;
    logic [4:0]  bit_index;
`ifdef JOYSER_TIMEOUT_EN
    logic        link_lost;
`endif

    int   n_tests = 0;
    int   n_fail = 0;
    int   fd_count = 0;
    logic exp_q[$];

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (!reset && frame_done) fd_count++;

    joy_serializer #(
        .LEAD_BITS(LEAD),
        .SYNC_STAGES(SYNC)
`ifdef JOYSER_TIMEOUT_EN
        , .TIMEOUT(1000)
`endif
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .joy_clk(joy_clk),
        .joy_load(joy_load),
        .joy_data(joy_data),
        .joystick1(joystick1),
        .joystick2(joystick2),
        .frame_done(frame_done),
        .bit_index(bit_index)
`ifdef JOYSER_TIMEOUT_EN
        , .link_lost(link_lost)
`endif
    );

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [11:0] j1, input logic [11:0] j2,
                                       input int unsigned n);
        int   k;
        logic b;
        k = int'(n) - int'(LEAD);
        b = 1'b1;
        case (k)
            0: b = j1[8];   1: b = j1[6];   2: b = j1[5];   3: b = j1[4];
            4: b = j1[3];   5: b = j1[2];   6: b = j1[1];   7: b = j1[0];
            8: b = j2[8];   9: b = j2[6];  10: b = j2[5];  11: b = j2[4];
           12: b = j2[3];  13: b = j2[2];  14: b = j2[1];  15: b = j2[0];
           16: b = j2[10]; 17: b = j2[11]; 18: b = j2[9];  19: b = j2[7];
           20: b = j1[10]; 21: b = j1[11]; 22: b = j1[9];  23: b = j1[7];
           default: b = 1'b1;
        endcase
        return b;
    endfunction

    task automatic push_frame(input logic [11:0] j1, input logic [11:0] j2);
        exp_q.delete();
        for (int unsigned n = 0; n < FLEN; n++) exp_q.push_back(frame_bit(j1, j2, n));
    endtask

    task automatic load_frame(input logic [11:0] j1, input logic [11:0] j2);
        joystick1 = j1;
        joystick2 = j2;
        joy_load  = 1'b0;
        tick(8);
        joy_load  = 1'b1;
        push_frame(j1, j2);
        tick(8);
    endtask

    task automatic serial_rise();
        logic e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stream_bit", 32'(joy_data), 32'(e));
        end
        joy_clk = 1'b1;
        tick(HALF);
        joy_clk = 1'b0;
        tick(HALF);
    endtask

    task automatic run_frame(input logic [11:0] j1, input logic [11:0] j2, input string tag);
        int fd0;
        load_frame(j1, j2);
        fd0 = fd_count;
        for (int unsigned r = 0; r < FLEN; r++) serial_rise();
        check({tag, "_frame_done"}, 32'(fd_count - fd0), 32'd1);
        check({tag, "_bit_index"}, 32'(bit_index), 32'(FLEN));
        check({tag, "_idle_data"}, 32'(joy_data), 32'd1);
    endtask

    initial begin
        int          fd0;
        logic [11:0] ra, rb;

        tick(4);
        check("reset_data", 32'(joy_data), 32'd1);
        check("reset_index", 32'(bit_index), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        for (int unsigned i = 0; i < 10; i++) begin
            tick(100);
            check("idle", {29'd0, joy_data, frame_done, |bit_index}, 32'b100);
        end

        // Snapshot test: inputs change mid-frame, stream keeps the loaded word
        load_frame(12'hFFE, 12'hFFF);
        joystick1 = 12'h000;
        fd0 = fd_count;
        for (int unsigned r = 0; r < FLEN; r++) serial_rise();
        check("snap_frame_done", 32'(fd_count - fd0), 32'd1);
        check("snap_bit_index", 32'(bit_index), 32'(FLEN));
        serial_rise();
        serial_rise();
        check("done_ignores_rise", 32'(bit_index), 32'(FLEN));
        check("done_single_pulse", 32'(fd_count - fd0), 32'd1);

        run_frame(12'h000, 12'hFFF, "zeros");

        // Abort a frame by loading after ten rises
        ra = 12'(($urandom));
        rb = 12'(($urandom));
        load_frame(ra, rb);
        fd0 = fd_count;
        for (int unsigned r = 0; r < 10; r++) serial_rise();
        check("pre_abort_index", 32'(bit_index), 32'd10);
        joy_load = 1'b0;
        tick(SYNC + 1);
        check("abort_index", 32'(bit_index), 32'd0);
        check("abort_data", 32'(joy_data), 32'(frame_bit(ra, rb, 0)));
        tick(5);
        joy_load = 1'b1;
        tick(8);
        check("abort_no_done", 32'(fd_count - fd0), 32'd0);

        // Coincident joy_clk rise and load assertion mid-frame
        run_frame(12'h5A5, 12'hA5A, "pattern");
        load_frame(12'h3C3, 12'hC3C);
        for (int unsigned r = 0; r < 5; r++) serial_rise();
        joy_load = 1'b0;
        joy_clk  = 1'b1;
        tick(8);
        check("coincident_index", 32'(bit_index), 32'd0);
        joy_load = 1'b1;
        tick(8);
        check("coincident_release_index", 32'(bit_index), 32'd0);
        joy_clk = 1'b0;
        tick(HALF);

        for (int unsigned i = 0; i < 2; i++) begin
            ra = 12'(($urandom));
            rb = 12'(($urandom));
            run_frame(ra, rb, "random");
        end

`ifdef JOYSER_TIMEOUT_EN
        load_frame(12'h000, 12'h000);
        tick(900 - 16);
        check("wd_not_lost", 32'(link_lost), 32'd0);
        tick(110);
        check("wd_lost", 32'(link_lost), 32'd1);
        check("wd_lost_data", 32'(joy_data), 32'd1);
        load_frame(12'h000, 12'h000);
        check("wd_cleared", 32'(link_lost), 32'd0);
        fd0 = fd_count;
        for (int unsigned r = 0; r < FLEN; r++) serial_rise();
        check("wd_frame_done", 32'(fd_count - fd0), 32'd1);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
